cb_cfg_chain: RTL and testbench

CB_CFG_CHAIN -- requirements
Module: cb_cfg_chain

---
 rtl/cb_pkg.sv | 46 ++++
 rtl/cb_mux_cell.sv | 48 ++++
 rtl/cb_cfg_chain.sv | 125 ++++++++++++
 tb/tb_cb_cfg_chain.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cb_pkg.sv
// Connection-box configuration chain: shared types and sizing helpers.
//
// Helpers compute the select widths, total configuration size and the bit
// offset of each output's {mode, select} field within the configuration word.
// Fields are packed LSB-first: single0_out, single1_out, clb0_input, clb1_input.
package cb_pkg;

    typedef enum logic [1:0] {
        CLS_SNG0 = 2'd0,
        CLS_SNG1 = 2'd1,
        CLS_CLB0 = 2'd2,
        CLS_CLB1 = 2'd3
    } cb_cls_e;

    // Track muxes see: const0, const1, both CLB output groups, the other track group.
    function automatic int cb_sng_sel(input int chn_w, input int clb_ow);
        return $clog2(chn_w + 2*clb_ow + 2);
    endfunction

    // CLB input muxes see: const0, const1, both track groups, the other CLB outputs.
    function automatic int cb_clb_sel(input int chn_w, input int clb_ow);
        return $clog2(clb_ow + 2*chn_w + 2);
    endfunction

    function automatic int cb_cfg_size(input int clb_iw, input int clb_ow, input int chn_w);
        return 2*chn_w*(cb_sng_sel(chn_w, clb_ow) + 1)
             + 2*clb_iw*(cb_clb_sel(chn_w, clb_ow) + 1);
    endfunction

    function automatic int cb_field_off(input cb_cls_e cls, input int idx,
                                        input int clb_iw, input int clb_ow, input int chn_w);
        int sng_f;
        int clb_f;
        int off;
        sng_f = cb_sng_sel(chn_w, clb_ow) + 1;
        clb_f = cb_clb_sel(chn_w, clb_ow) + 1;
        case (cls)
            CLS_SNG0: off = idx*sng_f;
            CLS_SNG1: off = chn_w*sng_f + idx*sng_f;
            CLS_CLB0: off = 2*chn_w*sng_f + idx*clb_f;
            default:  off = 2*chn_w*sng_f + clb_iw*clb_f + idx*clb_f;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/cb_mux_cell.sv
// One routing mux with an optional output register.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   sel_i        active select (index into data_i; out-of-range selects give 0)
//   mode_i       0: combinational output, 1: registered output (1-cycle latency)
//   data_i       mux inputs; the parent puts const0/const1 at indices 0/1
//   out_o        routed output
module cb_mux_cell #(
    parameter int IWIDTH = 26,
    parameter int SEL_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic              mode_i,
    input  logic [IWIDTH-1:0] data_i,
    output logic              out_o
);

    logic mux_val;
    logic out_d;
    logic out_q;

    // Explicit compare loop so selects >= IWIDTH fall through to 0.
    always_comb begin
        mux_val = 1'b0;
        for (int i = 0; i < IWIDTH; i++) begin
            if (sel_i == SEL_W'(i)) begin
                mux_val = data_i[i];
            end
        end
    end

    assign out_d = mux_val;

    // Free-running capture; the mode bit only picks which path is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_o = mode_i ? out_q : mux_val;

endmodule

// File: rtl/cb_cfg_chain.sv
// Connection box with a serial configuration chain and shadow (active) config.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cfg_in, cfg_en             serial config data and shift enable
//   cfg_commit                 copy shift chain into active config
//   cfg_out                    daisy-chain output (chain MSB)
//   clb0_output, clb1_output   same-tile / adjacent-tile CLB outputs
//   single0_in, single1_in     same-tile / adjacent-tile tracks
//   single0_out, single1_out   routed track outputs
//   clb0_input, clb1_input     routed CLB inputs
module cb_cfg_chain
    import cb_pkg::*;
#(
    parameter int CLB_IWIDTH = 10,
    parameter int CLB_OWIDTH = 4,
    parameter int CHN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_in,
    input  logic                  cfg_en,
    input  logic                  cfg_commit,
    output logic                  cfg_out,
    input  logic [CLB_OWIDTH-1:0] clb0_output,
    input  logic [CLB_OWIDTH-1:0] clb1_output,
    input  logic [CHN_WIDTH-1:0]  single0_in,
    input  logic [CHN_WIDTH-1:0]  single1_in,
    output logic [CHN_WIDTH-1:0]  single0_out,
    output logic [CHN_WIDTH-1:0]  single1_out,
    output logic [CLB_IWIDTH-1:0] clb0_input,
    output logic [CLB_IWIDTH-1:0] clb1_input
);

    localparam int SNG_SEL  = cb_sng_sel(CHN_WIDTH, CLB_OWIDTH);
    localparam int CLB_SEL  = cb_clb_sel(CHN_WIDTH, CLB_OWIDTH);
    localparam int CFG_SIZE = cb_cfg_size(CLB_IWIDTH, CLB_OWIDTH, CHN_WIDTH);
    localparam int SNG_IW   = CHN_WIDTH + 2*CLB_OWIDTH + 2;
    localparam int CLB_IW   = CLB_OWIDTH + 2*CHN_WIDTH + 2;

    logic [CFG_SIZE-1:0] chain_d, chain_q;
    logic [CFG_SIZE-1:0] cfg_d,   cfg_q;

    // Commit samples the pre-edge chain, so a same-cycle shift does not leak in.
    always_comb begin
        chain_d = chain_q;
        cfg_d   = cfg_q;
        if (cfg_en) begin
            chain_d = {chain_q[CFG_SIZE-2:0], cfg_in};
        end
        if (cfg_commit) begin
            cfg_d = chain_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
            cfg_q   <= '0;
        end else begin
            chain_q <= chain_d;
            cfg_q   <= cfg_d;
        end
    end

    assign cfg_out = chain_q[CFG_SIZE-1];

    // Mux source vectors, index 0 = const0, index 1 = const1.
    logic [SNG_IW-1:0] sng0_src, sng1_src;
    logic [CLB_IW-1:0] clb0_src, clb1_src;

    assign sng0_src = {single1_in, clb1_output, clb0_output, 2'b10};
    assign sng1_src = {single0_in, clb1_output, clb0_output, 2'b10};
    assign clb0_src = {clb1_output, single1_in, single0_in, 2'b10};
    assign clb1_src = {clb0_output, single1_in, single0_in, 2'b10};

    for (genvar i = 0; i < CHN_WIDTH; i++) begin : g_sng0
        localparam int OFF = cb_field_off(CLS_SNG0, i, CLB_IWIDTH, CLB_OWIDTH, CHN_WIDTH);
        cb_mux_cell #(.IWIDTH(SNG_IW), .SEL_W(SNG_SEL)) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .sel_i  (cfg_q[OFF +: SNG_SEL]),
            .mode_i (cfg_q[OFF + SNG_SEL]),
            .data_i (sng0_src),
            .out_o  (single0_out[i])
        );
    end

    for (genvar i = 0; i < CHN_WIDTH; i++) begin : g_sng1
        localparam int OFF = cb_field_off(CLS_SNG1, i, CLB_IWIDTH, CLB_OWIDTH, CHN_WIDTH);
        cb_mux_cell #(.IWIDTH(SNG_IW), .SEL_W(SNG_SEL)) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .sel_i  (cfg_q[OFF +: SNG_SEL]),
            .mode_i (cfg_q[OFF + SNG_SEL]),
            .data_i (sng1_src),
            .out_o  (single1_out[i])
        );
    end

    for (genvar i = 0; i < CLB_IWIDTH; i++) begin : g_clb0
        localparam int OFF = cb_field_off(CLS_CLB0, i, CLB_IWIDTH, CLB_OWIDTH, CHN_WIDTH);
        cb_mux_cell #(.IWIDTH(CLB_IW), .SEL_W(CLB_SEL)) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .sel_i  (cfg_q[OFF +: CLB_SEL]),
            .mode_i (cfg_q[OFF + CLB_SEL]),
            .data_i (clb0_src),
            .out_o  (clb0_input[i])
        );
    end

    for (genvar i = 0; i < CLB_IWIDTH; i++) begin : g_clb1
        localparam int OFF = cb_field_off(CLS_CLB1, i, CLB_IWIDTH, CLB_OWIDTH, CHN_WIDTH);
        cb_mux_cell #(.IWIDTH(CLB_IW), .SEL_W(CLB_SEL)) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .sel_i  (cfg_q[OFF +: CLB_SEL]),
            .mode_i (cfg_q[OFF + CLB_SEL]),
            .data_i (clb1_src),
            .out_o  (clb1_input[i])
        );
    end

endmodule

// File: tb/tb_cb_cfg_chain.sv
module tb_cb_cfg_chain;

    localparam int N = 332;
    // Field offsets at default parameters: track fields are 6 bits, CLB fields 7 bits.
    localparam int OFF_S0 = 0;
    localparam int OFF_S1 = 96;
    localparam int OFF_C0 = 192;
    localparam int OFF_C1 = 262;

    logic        clk;
    logic        rst_n;
    logic        cfg_in, cfg_en, cfg_commit;
    logic        cfg_out;
    logic [3:0]  clb0_output, clb1_output;
    logic [15:0] single0_in, single1_in;
    logic [15:0] single0_out, single1_out;
    logic [9:0]  clb0_input, clb1_input;

    int n_chk  = 0;
    int n_pass = 0;

    cb_cfg_chain dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_in      (cfg_in),
        .cfg_en      (cfg_en),
        .cfg_commit  (cfg_commit),
        .cfg_out     (cfg_out),
        .clb0_output (clb0_output),
        .clb1_output (clb1_output),
        .single0_in  (single0_in),
        .single1_in  (single1_in),
        .single0_out (single0_out),
        .single1_out (single1_out),
        .clb0_input  (clb0_input),
        .clb1_input  (clb1_input)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [N-1:0] put(input logic [N-1:0] v, input int off, input int w,
                                         input logic [7:0] sel, input logic mode);
        logic [N-1:0] r;
        r = v;
        for (int j = 0; j < w; j++) r[off+j] = sel[j];
        r[off+w] = mode;
        return r;
    endfunction

    // MSB is shifted first so that it ends up at chain[N-1].
    task automatic load_cfg(input logic [N-1:0] v);
        cfg_en = 1'b1;
        for (int i = N-1; i >= 0; i--) begin
            cfg_in = v[i];
            tick();
        end
        cfg_en = 1'b0;
        cfg_in = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    logic [N-1:0] v;
    logic [7:0]   pat;
    logic [7:0]   p;
    logic         prev;

    initial begin
        rst_n = 1'b0; cfg_in = 1'b0; cfg_en = 1'b0; cfg_commit = 1'b0;
        clb0_output = '0; clb1_output = '0; single0_in = '0; single1_in = '0;
        #2;
        chk("reset_outs", {single0_out, single1_out, clb0_input, clb1_input, cfg_out}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Chain test: A5 pattern then zeros; cfg_out replays it N cycles later.
        pat = 8'hA5;
        cfg_en = 1'b1;
        for (int t = 0; t < 2*N; t++) begin
            cfg_in = (t < N) ? pat[t % 8] : 1'b0;
            #1;
            chk("chain_out", {63'd0, cfg_out}, (t >= N) ? {63'd0, pat[(t-N) % 8]} : 64'd0);
            tick();
        end
        cfg_en = 1'b0;
        cfg_in = 1'b0;
        chk("chain_flushed", {63'd0, cfg_out}, 64'd0);

        // Every field = constant 1, registered; then reset mid-shift.
        v = '0;
        for (int i = 0; i < 16; i++) v = put(v, OFF_S0 + 6*i, 5, 8'd1, 1'b1);
        for (int i = 0; i < 16; i++) v = put(v, OFF_S1 + 6*i, 5, 8'd1, 1'b1);
        for (int i = 0; i < 10; i++) v = put(v, OFF_C0 + 7*i, 6, 8'd1, 1'b1);
        for (int i = 0; i < 10; i++) v = put(v, OFF_C1 + 7*i, 6, 8'd1, 1'b1);
        load_cfg(v);
        chk("ones_cfg_out", {63'd0, cfg_out}, 64'd1);
        commit();
        chk("ones_commit_edge", {48'd0, single0_out}, 64'd0);
        tick();
        chk("ones_outs", {single0_out, single1_out, clb0_input, clb1_input}, {52'd0, 52'hF_FFFF_FFFF_FFFF});
        cfg_en = 1'b1;
        cfg_in = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", {single0_out, single1_out, clb0_input, clb1_input}, 64'd0);
        chk("async_reset_cfg_out", {63'd0, cfg_out}, 64'd0);
        tick();
        cfg_en = 1'b0;
        cfg_in = 1'b0;
        rst_n = 1'b1;
        tick();
        commit();
        tick();
        chk("post_reset_clean", {single0_out, single1_out, clb0_input, clb1_input, cfg_out}, 64'd0);

        // Combinational route: single0_out[3] <- clb0_output[0].
        do_reset();
        load_cfg(put('0, OFF_S0 + 18, 5, 8'd2, 1'b0));
        clb0_output = 4'b0001;
        #1;
        chk("comb_before_commit", {63'd0, single0_out[3]}, 64'd0);
        commit();
        chk("comb_after_commit", {63'd0, single0_out[3]}, 64'd1);
        clb0_output = 4'b0000;
        #1;
        chk("comb_follow_lo", {63'd0, single0_out[3]}, 64'd0);
        clb0_output = 4'b0001;
        #1;
        chk("comb_follow_hi", {63'd0, single0_out[3]}, 64'd1);
        chk("comb_others", {48'd0, single0_out & 16'hFFF7}, 64'd0);
        clb0_output = 4'b0000;

        // Registered route: clb1_input[9] <- clb0_output[0], 1 cycle late.
        do_reset();
        load_cfg(put('0, OFF_C1 + 63, 6, 8'd34, 1'b1));
        commit();
        p = 8'b1011_0010;
        prev = 1'b0;
        for (int k = 0; k < 8; k++) begin
            clb0_output[0] = p[k];
            #1;
            chk("reg_route", {63'd0, clb1_input[9]}, {63'd0, prev});
            tick();
            prev = p[k];
        end
        clb0_output = 4'b0000;

        // Simultaneous shift and commit: pre-shift chain is what becomes active.
        do_reset();
        load_cfg(put('0, OFF_S0, 5, 8'd1, 1'b0));
        cfg_en = 1'b1;
        cfg_in = 1'b1;
        cfg_commit = 1'b1;
        tick();
        cfg_en = 1'b0;
        cfg_in = 1'b0;
        cfg_commit = 1'b0;
        chk("shift_commit_pre", {63'd0, single0_out[0]}, 64'd1);
        commit();
        chk("shift_commit_post", {63'd0, single0_out[0]}, 64'd0);

        // Select range boundaries with every input held at 1.
        do_reset();
        clb0_output = '1; clb1_output = '1; single0_in = '1; single1_in = '1;
        v = put('0, OFF_S1, 5, 8'd31, 1'b0);
        v = put(v, OFF_S1 + 6, 5, 8'd25, 1'b0);
        v = put(v, OFF_S1 + 12, 5, 8'd26, 1'b0);
        v = put(v, OFF_C0, 6, 8'd37, 1'b0);
        v = put(v, OFF_C0 + 7, 6, 8'd38, 1'b0);
        load_cfg(v);
        commit();
        chk("sel31_zero", {63'd0, single1_out[0]}, 64'd0);
        chk("sel25_last", {63'd0, single1_out[1]}, 64'd1);
        chk("sel26_zero", {63'd0, single1_out[2]}, 64'd0);
        chk("clbsel37_last", {63'd0, clb0_input[0]}, 64'd1);
        chk("clbsel38_zero", {63'd0, clb0_input[1]}, 64'd0);
        chk("unprog_sel0", {48'd0, single1_out & 16'hFFF8}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
